width_packer: RTL
=================

// Module: width_packer
// PURPOSE
//  Packs RATIO consecutive WIDTH-bit input beats into one RATIO*WIDTH-bit output word.
//  Uses valid/ready on both sides; in_last flushes a partial word with a lane count.
//  Generalises the fixed WIDTH -> 2*WIDTH datapath to any ratio, and adds flow control and framing.
//  Protocol checkers are simulation-only, inside a synthesis translate_off/on region.
// PARAMETERS
//  WIDTH  8  bits per input beat (>=1)
//  RATIO  2  input beats per output word (>=2); OUT_WIDTH = WIDTH*RATIO (localparam)
//  CNT_W  $clog2(RATIO+1)  width of out_count (localparam)
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous, active-low reset
//  in_valid   in   1          input beat valid
//  in_ready   out  1          input beat accepted when in_valid & in_ready
//  in_data    in   WIDTH      input beat
//  in_last    in   1          beat closes current word (flush)
//  out_valid  out  1          output word valid
//  out_ready  in   1          output word consumed when out_valid & out_ready
//  out_data   out  OUT_WIDTH  packed word; beat k in bits [k*WIDTH +: WIDTH]
//  out_count  out  CNT_W      valid lanes in out_data (1..RATIO)
//  out_last   out  1          word was closed by in_last
// BEHAVIOUR
//  - Reset (reset=0, async): out_valid=0, out_data=0, out_count=0, out_last=0.
//    Also clears lane index and accumulator. Reset mid-word discards the partial word.
//    in_ready comes out of reset as 1.
//  - Storage: accumulator (OUT_WIDTH) + lane index idx (0..RATIO-1) + output register.
//  - FSM FILL: accepted beat writes lane idx and increments idx.
//    The beat is "closing" if idx==RATIO-1 or in_last=1.
//  - On an accepted closing beat: the accumulator (including this beat) moves to the output register.
//    out_count = idx+1; out_last = in_last; idx <- 0; accumulator cleared.
//    Unused upper lanes of out_data are 0.
//  - FSM HOLD = out_valid=1 and not consumed.
//    Non-closing beats are still accepted into the accumulator.
//  - in_ready = !(out_valid & !out_ready) | (idx != RATIO-1), combinational.
//    A closing beat via in_last at idx<RATIO-1 also stalls while HOLD:
//    in_ready is low whenever out_valid & !out_ready & in_last & in_valid.
//  - Latency: out_valid rises the cycle after the closing beat is accepted.
//    No bubble between back-to-back words when out_ready=1: full throughput of 1 beat/cycle.
//  - Simultaneous consume + new closing beat: the output register reloads in the same cycle.
//    out_valid stays 1.
//  - out_* are stable while out_valid & !out_ready. in_last on lane 0 yields out_count=1.
//  - Sim-only (translate_off): $error if RATIO<2.
//    $error if in_data/in_last change while in_valid & !in_ready.
// TESTING
//  1 W=8,R=4; beats 11,22,33,44, out_ready=1
//    -> out_data=44332211, out_count=4, out_last=0, one cycle after beat 4.
//  2 beats AA,BB with in_last on BB
//    -> out_data=0000BBAA, out_count=2, out_last=1; next word starts at lane 0.
//  3 out_ready=0 after a full word; send 3 more beats then a 4th
//    -> first 3 accepted, 4th stalls (in_ready=0) until out_ready=1; no data loss.
//  4 continuous 16 beats with out_ready=1
//    -> 4 words on consecutive-every-4th cycles, in_ready never drops.
//  5 reset=0 asserted after 2 beats, then 4 beats
//    -> outputs 0 immediately; next word contains only the post-reset beats, count=4.
//  6 R=2 default, in_last on every beat -> every word out_count=1, upper lane 0.

Source files
------------

// File: rtl/width_packer_if.sv
// rtl/width_packer_if.sv - stream bundle for width_packer: narrow input beats in, packed words out
//
// Purpose
//   Groups both valid/ready handshakes of the packer so they travel as one port.
//   The producer/consumer side uses the master modport; the packer uses slave.
//
// Signal summary
//   in_valid   producer -> packer   input beat valid
//   in_ready   packer -> producer   beat accepted when in_valid & in_ready
//   in_data    producer -> packer   WIDTH-bit beat
//   in_last    producer -> packer   beat closes the current word
//   out_valid  packer -> consumer   packed word valid
//   out_ready  consumer -> packer   word consumed when out_valid & out_ready
//   out_data   packer -> consumer   WIDTH*RATIO-bit word, beat k at [k*WIDTH +: WIDTH]
//   out_count  packer -> consumer   number of valid lanes (1..RATIO)
//   out_last   packer -> consumer   word was closed by in_last

interface width_packer_if #(
    parameter int WIDTH = 8,
    parameter int RATIO = 2
);
    localparam int OUT_WIDTH = WIDTH * RATIO;
    localparam int CNT_W     = $clog2(RATIO + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;

    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [CNT_W-1:0]     out_count;
    logic                 out_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_count,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_count,
        output out_last
    );
endinterface

// File: rtl/width_packer.sv
// rtl/width_packer.sv - packs RATIO narrow beats into one wide word with flush-on-last framing
//
// Purpose
//   Collects RATIO consecutive WIDTH-bit beats into a WIDTH*RATIO-bit word.
//   A beat with in_last set closes the word early; the word then carries the
//   number of lanes filled in out_count and unused upper lanes read as zero.
//   Full throughput of one beat per cycle when the consumer keeps out_ready high.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset; discards any partial word
//   bus    slave modport of width_packer_if (input beat stream + output word stream)
//
// Structure
//   r_acc    accumulator holding the lanes of the word being built
//   r_idx    lane the next accepted beat is written to
//   r_out_*  output register, presented while r_state == ST_HOLD

module width_packer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 2
) (
    input  logic          clk,
    input  logic          reset,
    width_packer_if.slave bus
);

    localparam int OUT_WIDTH = WIDTH * RATIO;
    localparam int CNT_W     = $clog2(RATIO + 1);
    localparam int IDX_W     = (RATIO > 2) ? $clog2(RATIO) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    // ST_FILL: output register empty; ST_HOLD: output register holds a word.
    // Beats keep flowing into the accumulator in both states.
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]           r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [OUT_WIDTH-1:0] r_acc;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0]     r_out_count;
    logic                 r_out_last;

    logic                 w_out_valid;
    logic                 w_hold;
    logic                 w_last_lane;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_close;
    logic                 w_consume;
    logic [OUT_WIDTH-1:0] w_word;

    assign w_out_valid = (r_state == ST_HOLD);

    // The output register is blocked when it holds a word the consumer is not
    // taking this cycle.
    assign w_hold      = w_out_valid & ~bus.out_ready;
    assign w_last_lane = (r_idx == LAST_IDX);

    // Only a beat that would close a word needs the output register, so only
    // such beats stall while it is blocked. Whether a beat closes early is known
    // from in_last, which makes in_ready depend combinationally on in_valid and
    // in_last.
    assign w_in_ready  = ~w_hold | (~w_last_lane & ~(bus.in_valid & bus.in_last));

    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_close     = w_accept & (w_last_lane | bus.in_last);
    assign w_consume   = w_out_valid & bus.out_ready;

    // Accumulator with the incoming beat merged into the current lane. Lanes
    // above r_idx are still zero because the accumulator is cleared every time
    // a word is closed, which gives the zero-filled upper lanes on early flush.
    always_comb begin
        w_word = r_acc;
        w_word[r_idx*WIDTH +: WIDTH] = bus.in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_FILL;
            r_idx       <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_close) begin
                // A closing beat is only accepted when the output register is
                // free or being consumed this cycle, so reloading here never
                // overwrites an unconsumed word and out_valid stays high on
                // back-to-back words.
                r_out_data  <= w_word;
                r_out_count <= CNT_W'(r_idx) + CNT_W'(1);
                r_out_last  <= bus.in_last;
                r_state     <= ST_HOLD;
                r_idx       <= '0;
                r_acc       <= '0;
            end else begin
                if (w_accept) begin
                    r_acc <= w_word;
                    r_idx <= r_idx + IDX_W'(1);
                end
                if (w_consume) begin
                    r_state <= ST_FILL;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;
    assign bus.out_last  = r_out_last;

`ifndef SYNTHESIS
    // Simulation-only protocol checks: a stalled beat must be held unchanged
    // until it is accepted, and the ratio must describe a real packing.
    logic             r_chk_stall;
    logic [WIDTH-1:0] r_chk_data;
    logic             r_chk_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_chk_stall <= 1'b0;
            r_chk_data  <= '0;
            r_chk_last  <= 1'b0;
        end else begin
            r_chk_stall <= bus.in_valid & ~w_in_ready;
            r_chk_data  <= bus.in_data;
            r_chk_last  <= bus.in_last;
            if (RATIO < 2) begin
                $error("width_packer: RATIO must be at least 2");
            end
            if (r_chk_stall && bus.in_valid &&
                ((bus.in_data != r_chk_data) || (bus.in_last != r_chk_last))) begin
                $error("width_packer: in_data/in_last changed while beat was stalled");
            end
        end
    end
`endif

endmodule
